// File: rtl/panda_pkg.sv
// Shared fetch-stage types and constants for the Panda front end.
package panda_pkg;

    typedef enum logic [1:0] {StIdle, StReq, StWait} fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/panda_fetch_buf.sv
// Single-entry instruction/PC holding buffer between fetch and decode.
module panda_fetch_buf
    import panda_pkg::*;
#(
    parameter int unsigned      Width    = 32,
    parameter logic [Width-1:0] NopInstr = Width'(NOP_INSTR)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             consume_i,
    input  logic             flush_i,
    input  logic [Width-1:0] instr_i,
    input  logic [Width-1:0] pc_i,
    output logic             valid_o,
    output logic [Width-1:0] instr_o,
    output logic [Width-1:0] pc_o
);

    logic             valid_q, valid_d;
    logic [Width-1:0] instr_q, instr_d;
    logic [Width-1:0] pc_q, pc_d;

    // Flush beats load beats consume; a same-cycle reload keeps the entry valid.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
            instr_d = NopInstr;
        end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else if (consume_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            instr_q <= NopInstr;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/panda_fetch_ctrl.sv
// Panda fetch sequencer: one outstanding imem request feeding a single-entry decode buffer.
// Build option PANDA_FETCH_PERF_EN adds saturating fetch_cnt_o / kill_cnt_o counters.
module panda_fetch_ctrl
    import panda_pkg::*;
#(
    parameter int unsigned      Width    = 32,
    parameter logic [Width-1:0] NopInstr = Width'(NOP_INSTR)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] pc_i,
    output logic             pc_stall_o,
    output logic             pc_change_flow_o,
    output logic [Width-1:0] pc_target_o,
    input  logic             redirect_i,
    input  logic [Width-1:0] redirect_addr_i,
    output logic             imem_req_o,
    output logic [Width-1:0] imem_addr_o,
    input  logic             imem_gnt_i,
    input  logic             imem_rvalid_i,
    input  logic [Width-1:0] imem_rdata_i,
    output logic             instr_valid_o,
    output logic [Width-1:0] instr_o,
    output logic [Width-1:0] instr_pc_o,
    input  logic             id_ready_i
`ifdef PANDA_FETCH_PERF_EN
    ,
    output logic [31:0]      fetch_cnt_o,
    output logic [31:0]      kill_cnt_o
`endif
);

    fetch_state_e     state_q, state_d;
    logic             kill_q, kill_d;
    logic [Width-1:0] pend_pc_q, pend_pc_d;
    logic             grant, in_wait, resp_load, resp_drop;

    assign grant     = imem_req_o & imem_gnt_i;
    assign in_wait   = (state_q == StWait);
    // A response that coincides with a redirect is stale even without the kill flag.
    assign resp_load = in_wait & imem_rvalid_i & ~kill_q & ~redirect_i;
    assign resp_drop = in_wait & imem_rvalid_i & (kill_q | redirect_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            kill_q    <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            kill_q    <= kill_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        kill_d    = kill_q;
        pend_pc_d = pend_pc_q;
        unique case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                if (grant) begin
                    state_d   = StWait;
                    pend_pc_d = pc_i;
                    kill_d    = redirect_i;
                end
            end
            StWait: begin
                if (imem_rvalid_i) begin
                    state_d = StReq;
                    kill_d  = 1'b0;
                end else if (redirect_i) begin
                    kill_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        imem_req_o       = (state_q == StReq) & (~instr_valid_o | id_ready_i);
        imem_addr_o      = pc_i;
        pc_change_flow_o = redirect_i;
        pc_target_o      = redirect_addr_i;
        pc_stall_o       = ~(imem_req_o & imem_gnt_i) & ~redirect_i;
    end

    panda_fetch_buf #(
        .Width    (Width),
        .NopInstr (NopInstr)
    ) u_buf (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (resp_load),
        .consume_i (instr_valid_o & id_ready_i),
        .flush_i   (redirect_i),
        .instr_i   (imem_rdata_i),
        .pc_i      (pend_pc_q),
        .valid_o   (instr_valid_o),
        .instr_o   (instr_o),
        .pc_o      (instr_pc_o)
    );

`ifdef PANDA_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, kill_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            if (resp_load && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (resp_drop && (kill_cnt_q != 32'hFFFF_FFFF)) kill_cnt_q <= kill_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign kill_cnt_o  = kill_cnt_q;
`endif

endmodule
